// File: rtl/vault_access_controller.sv
// Vault door controller: PIN check on a debounced open push, failed-attempt lockout, close/auto-close gated by safe state.
// Latency: raw push edge -> press event = 2 sync + DEBOUNCE_CYCLES + 1 clocks; press -> state change on the following edge.
// Backpressure: none; all inputs are sampled levels and press events are dropped in states that do not accept them.
//
// Ports:
//   Clk, ResetN              clock and asynchronous active-low reset
//   PINIn                    raw slide-switch PIN
//   OpenPush, ClosePush      raw push buttons (bouncy)
//   SafeStatus               1 = safe is open; blocks vault close
//   VaultStatus              1 = vault open (state OPEN)
//   InvalidLED               wrong PIN or refused close, held until cleared
//   LockoutLED               lockout active
//   FailCount                consecutive failed attempts
//   StateOut                 00 LOCKED, 01 VALIDATE, 10 OPEN, 11 LOCKOUT
module vault_access_controller #(
    parameter int unsigned      PIN_W             = 4,
    parameter logic [PIN_W-1:0] VAULT_PIN         = 4'b0101,
    parameter int unsigned      MAX_FAILS         = 3,
    parameter int unsigned      DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned      LOCKOUT_CYCLES    = 50000000,
    parameter int unsigned      AUTO_CLOSE_CYCLES = 500000000
) (
    input  logic                               Clk,
    input  logic                               ResetN,
    input  logic [PIN_W-1:0]                   PINIn,
    input  logic                               OpenPush,
    input  logic                               ClosePush,
    input  logic                               SafeStatus,
    output logic                               VaultStatus,
    output logic                               InvalidLED,
    output logic                               LockoutLED,
    output logic [$clog2(MAX_FAILS+1)-1:0]     FailCount,
    output logic [1:0]                         StateOut
);

    localparam logic [1:0] LOCKED   = 2'b00;
    localparam logic [1:0] VALIDATE = 2'b01;
    localparam logic [1:0] OPEN     = 2'b10;
    localparam logic [1:0] LOCKOUT  = 2'b11;

    localparam int unsigned FC_W = $clog2(MAX_FAILS + 1);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LO_W = $clog2(LOCKOUT_CYCLES + 1);
    // +2 keeps the width at least 1 bit when auto-close is disabled (0).
    localparam int unsigned AC_W = $clog2(AUTO_CLOSE_CYCLES + 2);
    localparam bit          AC_EN = (AUTO_CLOSE_CYCLES != 0);

    localparam logic [FC_W-1:0] FC_MAX  = FC_W'(MAX_FAILS);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LO_W-1:0] LO_LAST = LO_W'(LOCKOUT_CYCLES - 1);
    localparam logic [AC_W-1:0] AC_LAST = AC_W'(AC_EN ? (AUTO_CLOSE_CYCLES - 1) : 0);

    // Button index 0 = open, 1 = close.
    logic [1:0]       btnMeta;
    logic [1:0]       btnSync;
    logic [1:0]       dbLevel;
    logic [1:0]       dbLevelDly;
    logic [1:0]       pressEvt;
    logic [DB_W-1:0]  dbCnt [2];

    logic [PIN_W-1:0] pinMeta;
    logic [PIN_W-1:0] pinSync;
    logic             safeMeta;
    logic             safeSync;

    logic [1:0]       state;
    logic [PIN_W-1:0] pinReg;
    logic [LO_W-1:0]  lockCnt;
    logic [AC_W-1:0]  autoCnt;
    logic [FC_W-1:0]  failNext;

    logic openEvt;
    logic closeEvt;

    assign openEvt  = pressEvt[0];
    assign closeEvt = pressEvt[1];

    // Synchronisers and per-button debounce. The debounced level only moves
    // after the synchronised value has disagreed with it for DEBOUNCE_CYCLES
    // consecutive clocks; any agreement in between restarts the count.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            btnMeta    <= '0;
            btnSync    <= '0;
            pinMeta    <= '0;
            pinSync    <= '0;
            safeMeta   <= 1'b0;
            safeSync   <= 1'b0;
            dbLevel    <= '0;
            dbLevelDly <= '0;
            pressEvt   <= '0;
            for (int i = 0; i < 2; i++) begin
                dbCnt[i] <= '0;
            end
        end else begin
            btnMeta    <= {ClosePush, OpenPush};
            btnSync    <= btnMeta;
            pinMeta    <= PINIn;
            pinSync    <= pinMeta;
            safeMeta   <= SafeStatus;
            safeSync   <= safeMeta;
            dbLevelDly <= dbLevel;
            // Rising edge of the debounced level only; releases make no event.
            pressEvt   <= dbLevel & ~dbLevelDly;
            for (int i = 0; i < 2; i++) begin
                if (btnSync[i] != dbLevel[i]) begin
                    if (dbCnt[i] == DB_LAST) begin
                        dbLevel[i] <= btnSync[i];
                        dbCnt[i]   <= '0;
                    end else begin
                        dbCnt[i] <= dbCnt[i] + DB_W'(1);
                    end
                end else begin
                    dbCnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        failNext = FailCount;
        if (FailCount != FC_MAX) begin
            failNext = FailCount + FC_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state      <= LOCKED;
            pinReg     <= '0;
            lockCnt    <= '0;
            autoCnt    <= '0;
            FailCount  <= '0;
            InvalidLED <= 1'b0;
        end else begin
            case (state)
                LOCKED: begin
                    if (openEvt) begin
                        state      <= VALIDATE;
                        pinReg     <= pinSync;
                        InvalidLED <= 1'b0;
                    end
                end
                VALIDATE: begin
                    if (pinReg == VAULT_PIN) begin
                        state      <= OPEN;
                        FailCount  <= '0;
                        InvalidLED <= 1'b0;
                        autoCnt    <= '0;
                    end else begin
                        FailCount  <= failNext;
                        InvalidLED <= 1'b1;
                        if (failNext == FC_MAX) begin
                            state   <= LOCKOUT;
                            lockCnt <= '0;
                        end else begin
                            state <= LOCKED;
                        end
                    end
                end
                OPEN: begin
                    // Close wins over a simultaneous open; open alone is ignored
                    // apart from restarting the idle timer.
                    if (closeEvt) begin
                        autoCnt <= '0;
                        if (!safeSync) begin
                            state      <= LOCKED;
                            InvalidLED <= 1'b0;
                        end else begin
                            InvalidLED <= 1'b1;
                        end
                    end else if (openEvt || safeSync) begin
                        autoCnt <= '0;
                    end else if (AC_EN) begin
                        if (autoCnt == AC_LAST) begin
                            state      <= LOCKED;
                            InvalidLED <= 1'b0;
                            autoCnt    <= '0;
                        end else begin
                            autoCnt <= autoCnt + AC_W'(1);
                        end
                    end
                end
                LOCKOUT: begin
                    if (lockCnt == LO_LAST) begin
                        state      <= LOCKED;
                        FailCount  <= '0;
                        InvalidLED <= 1'b0;
                        lockCnt    <= '0;
                    end else begin
                        lockCnt <= lockCnt + LO_W'(1);
                    end
                end
                default: begin
                    state <= LOCKED;
                end
            endcase
        end
    end

    assign VaultStatus = (state == OPEN);
    assign LockoutLED  = (state == LOCKOUT);
    assign StateOut    = state;

endmodule
